// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: fades current RGB levels toward an accepted target, one level per step tick,
// and drives active-low RGB pads with per-channel PWM. Optional: `RGB_PWM_FADER_GAMMA_EN.
// Ports: clk, rst_n (async low); in_valid/in_ready + in_r/in_g/in_b target; busy; RGB_R/G/B pads.
module rgb_pwm_fader #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 46875
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] in_r,
  input  logic [PWM_BITS-1:0] in_g,
  input  logic [PWM_BITS-1:0] in_b,
  output logic                busy,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  typedef enum logic {IDLE, FADE} state_t;

  state_t              state;
  logic [PWM_BITS-1:0] cur_r, cur_g, cur_b;
  logic [PWM_BITS-1:0] tgt_r, tgt_g, tgt_b;
  logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
  logic [PWM_BITS-1:0] nxt_r, nxt_g, nxt_b;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SW-1:0]       step_cnt;
  logic                tick, accept, same, done;

  function automatic logic [PWM_BITS-1:0] toward(
    input logic [PWM_BITS-1:0] c,
    input logic [PWM_BITS-1:0] t
  );
    logic [PWM_BITS-1:0] r;
    r = c;
    unique case (1'b1)
      (c < t): r = c + 1'b1;
      (c > t): r = c - 1'b1;
      default: r = c;
    endcase
    return r;
  endfunction

  // Gamma build squares the level at full width and keeps the top half.
  function automatic logic [PWM_BITS-1:0] shade(
    input logic [PWM_BITS-1:0] l
  );
`ifdef RGB_PWM_FADER_GAMMA_EN
    return PWM_BITS'(({{PWM_BITS{1'b0}}, l} *
                      {{PWM_BITS{1'b0}}, l}) >> PWM_BITS);
`else
    return l;
`endif
  endfunction

  always_comb begin
    nxt_r  = toward(cur_r, tgt_r);
    nxt_g  = toward(cur_g, tgt_g);
    nxt_b  = toward(cur_b, tgt_b);
    tick   = (state == FADE) && (step_cnt == STEP_LAST);
    accept = in_valid && in_ready;
    same   = (in_r == cur_r) && (in_g == cur_g) && (in_b == cur_b);
    done   = (nxt_r == tgt_r) && (nxt_g == tgt_g) && (nxt_b == tgt_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      cur_r    <= '0;
      cur_g    <= '0;
      cur_b    <= '0;
      tgt_r    <= '0;
      tgt_g    <= '0;
      tgt_b    <= '0;
      step_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            tgt_r    <= in_r;
            tgt_g    <= in_g;
            tgt_b    <= in_b;
            step_cnt <= '0;
            if (!same) begin
              state    <= FADE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        FADE: begin
          step_cnt <= tick ? '0 : step_cnt + 1'b1;
          if (tick) begin
            cur_r <= nxt_r;
            cur_g <= nxt_g;
            cur_b <= nxt_b;
            if (done) begin
              state    <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Duty only reloads at the period boundary so a step never glitches mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_r  <= '0;
      duty_g  <= '0;
      duty_b  <= '0;
      RGB_R   <= 1'b1;
      RGB_G   <= 1'b1;
      RGB_B   <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == PWM_MAX) begin
        duty_r <= shade(cur_r);
        duty_g <= shade(cur_g);
        duty_b <= shade(cur_b);
      end
      RGB_R <= ~(duty_r > pwm_cnt);
      RGB_G <= ~(duty_g > pwm_cnt);
      RGB_B <= ~(duty_b > pwm_cnt);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: randomized + directed bench for rgb_pwm_fader
// against a transaction-level model of levels, fade lengths and duty.
module tb_rgb_pwm_fader;

  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready, busy;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic       RGB_R, RGB_G, RGB_B;

  int n_checks = 0;
  int n_fail   = 0;
  int m_r = 0, m_g = 0, m_b = 0;
  int last_len = 0;

  always #5 if (clk_en) clk = ~clk;

  rgb_pwm_fader #(.PWM_BITS(8), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .busy(busy),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int ref_duty(input int l);
`ifdef RGB_PWM_FADER_GAMMA_EN
    return (l * l) / 256;
`else
    return l;
`endif
  endfunction

  // Offer a colour; exp_wait >= 0 checks how many cycles in_ready stayed low.
  task automatic xfer(input int r, input int g, input int b,
                      input int exp_wait);
    int n, d;
    in_r = 8'(r);
    in_g = 8'(g);
    in_b = 8'(b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (exp_wait >= 0) check("ready_wait", n, exp_wait);
    @(posedge clk);
    d = absd(m_r, r);
    if (absd(m_g, g) > d) d = absd(m_g, g);
    if (absd(m_b, b) > d) d = absd(m_b, b);
    last_len = d * STEP;
    m_r = r;
    m_g = g;
    m_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, last_len);
    check({tag, "_rdy"}, int'(in_ready), 1);
  endtask

  task automatic pwm_check(input string tag);
    int lr, lg, lb;
    lr = 0; lg = 0; lb = 0;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      lr += int'(!RGB_R);
      lg += int'(!RGB_G);
      lb += int'(!RGB_B);
      @(negedge clk);
    end
    check({tag, "_r"}, lr, ref_duty(m_r));
    check({tag, "_g"}, lg, ref_duty(m_g));
    check({tag, "_b"}, lb, ref_duty(m_b));
  endtask

  initial begin
    int bad, mode, r, g, b;

    // Async reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1;
    check("rst_pads", int'({RGB_R, RGB_G, RGB_B}), 7);
    check("rst_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    #5 rst_n = 1'b1;
    #5 clk_en = 1'b1;
    @(negedge clk);
    bad = 0;
    repeat (1000) begin
      if ({RGB_R, RGB_G, RGB_B} != 3'b111) bad++;
      @(negedge clk);
    end
    check("idle_pads", bad, 0);

    // No-change target never raises busy.
    xfer(0, 0, 0, 0);
    bad = 0;
    repeat (8) begin
      if (busy || !in_ready) bad++;
      @(negedge clk);
    end
    check("same_busy", bad, 0);
    wait_done("same_len");

    // Full red fade with blue held upstream during it.
    xfer(255, 0, 0, 0);
    xfer(0, 0, 255, last_len);
    wait_done("hold_len");
    pwm_check("blue");

    xfer(128, 128, 128, 0);
    wait_done("mid_len");
    pwm_check("mid");
    xfer(0, 64, 128, 0);
    wait_done("down_len");
    pwm_check("down");

    xfer(128, 255, 15, 0);
    wait_done("gam_len");
    pwm_check("gam");

    // Reset in the middle of a fade, clock stopped.
    xfer(200, 100, 50, 0);
    repeat (100) @(negedge clk);
    clk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_pads", int'({RGB_R, RGB_G, RGB_B}), 7);
    m_r = 0; m_g = 0; m_b = 0;
    #5 rst_n = 1'b1;
    #5 clk_en = 1'b1;
    @(negedge clk);
    pwm_check("post_rst");

    for (int i = 0; i < 12; i++) begin
      mode = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 255));
      g = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if (mode == 0) begin
        r = m_r; g = m_g; b = m_b;
      end else if (mode == 1) begin
        r = (r & 1) * 255;
        g = (g & 1) * 255;
        b = (b & 1) * 255;
      end
      if (mode == 3) begin
        xfer(r, g, b, 0);
        xfer(int'($urandom_range(0, 255)), m_g, 255 - m_b, last_len);
      end else begin
        xfer(r, g, b, 0);
      end
      wait_done("rnd_len");
      pwm_check("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Downstream LED driver stage for the RGB party-light colour sequencer.
- Accepts an 8-bit-per-channel target colour over a valid/ready handshake.
- Fades linearly from the current colour to the target, one level per step tick.
- Drives the active-low RGB_R/RGB_G/RGB_B pads with per-channel PWM, giving smooth colour transitions instead of hard on/off switching.

Parameters:
- PWM_BITS, 8: PWM counter and level width; PWM period is 2^PWM_BITS cycles.
- STEP_CYCLES, 46875: clk cycles per fade step (12 MHz / 256). A full 0-to-255 fade takes about 1 s.

Ports:
- clk  input  1  system clock, 12 MHz
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  target colour valid
- in_ready  output  1  block can accept a target
- in_r  input  PWM_BITS  red target level
- in_g  input  PWM_BITS  green target level
- in_b  input  PWM_BITS  blue target level
- busy  output  1  fade in progress
- RGB_R  output  1  red pad, active-low (0 = LED on)
- RGB_G  output  1  green pad, active-low
- RGB_B  output  1  blue pad, active-low

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release):
  - RGB_R/G/B = 1 (off); in_ready = 1; busy = 0.
  - Current levels, targets, duty shadows, pwm_cnt and step_cnt = 0.
  - State = IDLE.
  - Mid-fade reset aborts the fade immediately, with no clock edge required.
- FSM states:
  - IDLE: in_ready = 1, busy = 0.
  - FADE: in_ready = 0, busy = 1.
- Accept occurs on a cycle with in_valid && in_ready:
  - Latch in_r/in_g/in_b into the target registers.
  - If all three targets equal the current levels, stay in IDLE.
  - Otherwise go to FADE next cycle with step_cnt = 0.
- FADE:
  - step_cnt counts 0..STEP_CYCLES-1 and wraps.
  - On each cycle with step_cnt == STEP_CYCLES-1 (a tick), each current level moves by exactly 1 toward its target. Equal channels hold. Levels never overshoot.
  - When the tick makes all channels equal to their targets, the next state is IDLE. in_ready rises on the cycle after that final tick.
  - Fade length = max per-channel |target - current| ticks, which is that difference × STEP_CYCLES cycles.
- in_valid during FADE: ignored, no accept. The upstream stage must hold the colour until it sees in_ready.
- Arithmetic: levels are unsigned PWM_BITS wide. Increment and decrement never wrap past 0 or 2^PWM_BITS-1.
- PWM:
  - pwm_cnt is free-running from 0 to 2^PWM_BITS-1, then wraps. It runs in every state.
  - Duty shadow per channel is loaded from the current level (or from the gamma value) on the cycle pwm_cnt == max. A fade step therefore never changes duty mid-period.
  - Channel on = duty > pwm_cnt.
  - Duty 0 means always off. Duty 255 means on for 255 of every 256 cycles.
  - Pad = ~on, registered, so there is 1 cycle of latency from the compare to the pad.
- Latency:
  - Accept to first visible change is at most STEP_CYCLES + 2^PWM_BITS + 1 cycles.
  - The new duty is visible from the first PWM period that starts after the shadow load.

Optional Feature:
- Macro: RGB_PWM_FADER_GAMMA_EN.
- Defined: duty shadow = (level × level) >> PWM_BITS, using a full-width 2×PWM_BITS product. This gives a perceptual gamma of about 2. Examples: 128 → 64, 255 → 254, 15 → 0.
- Undefined: duty shadow = level, giving linear brightness.
- Handshake, fade timing and reset values are identical in both builds.

Test Plan:
All scenarios use STEP_CYCLES = 4 and PWM_BITS = 8.
1. Reset (assert rst_n = 0 with clk stopped, then release) -> pads = 3'b111 immediately; in_ready = 1; busy = 0; pads stay 111 for 1000 cycles.
2. Accept (255,0,0) from reset -> busy = 1 for 255 × 4 = 1020 cycles, then in_ready = 1. Next full PWM period: RGB_R low 255/256 cycles; RGB_G and RGB_B high throughout.
3. Hold in_valid with (0,0,255) during the fade in scenario 2 -> not accepted while busy. Accepted on the first cycle in_ready = 1. Final state: R = 0, B = 255 after 255 further ticks.
4. Accept (0,0,0) with current (0,0,0) -> in_ready stays 1, busy never asserts.
5. From (128,128,128), accept (0,64,128) -> G reaches 64 after 64 ticks; R reaches 0 after 128 ticks; B is constant. busy falls after 512 cycles. Duty never changes except at a pwm_cnt wrap.
6. With RGB_PWM_FADER_GAMMA_EN defined, settle at (128,255,15) -> per period, R low 64 cycles, G low 254 cycles, B never low.
